serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes `WIDTH`-bit operands `STEP` bits per clock through a rippled chain of full-adder cells, carrying between slices in a flip-flop. It is the registered, area-lean successor to our single-bit combinational adder cell. The block serves as the arithmetic unit behind the datapath exercises. A start/busy/done handshake frames each operation, and results hold stable until the next accepted start.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/fa_cell.sv | 13 +
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
// Slice count and counter width are derived here so every user sizes them identically.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int slice_count(input int width, input int step);
        return (step > 0) ? (width / step) : 1;
    endfunction

    // Counter never narrower than one bit, even for a single slice.
    function automatic int count_width(input int slices);
        return (slices <= 2) ? 1 : $clog2(slices);
    endfunction

    function automatic bit params_ok(input int width, input int step);
        return (width >= 2) && (step >= 1) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; chained STEP-deep to form one slice of the serial adder.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: STEP bits per clock through a rippled fa_cell chain,
// with the inter-slice carry held in a flop and a start/busy/done handshake.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = slice_count(WIDTH, STEP);
    localparam int CW = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (!params_ok(WIDTH, STEP)) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [STEP:0]    chain_c;
    logic [STEP-1:0]  slice_sum;

    assign chain_c[0] = carry_q;

    generate
        for (genvar i = 0; i < STEP; i++) begin : g_cell
            fa_cell u_fa (
                .x     (a_q[i]),
                .y     (b_q[i]),
                .c_in  (chain_c[i]),
                .s     (slice_sum[i]),
                .c_out (chain_c[i+1])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and preload the carry with 1.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> STEP;
                b_d     = b_q >> STEP;
                psum_d  = (psum_q >> STEP) | (WIDTH'(slice_sum) << (WIDTH - STEP));
                carry_d = chain_c[STEP];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = psum_d;
                    c_out_d = chain_c[STEP];
                    ovf_d   = chain_c[STEP] ^ chain_c[STEP-1];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-bit-per-cycle and a 16-bit/4-bits-per-cycle instance,
// results checked through per-instance expectation queues.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, c8, ovf8;
    logic [7:0]  s8;

    logic        start16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, done16, c16, ovf16;
    logic [15:0] s16;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } result_t;

    typedef struct {
        bit          wide;
        logic [15:0] a;
        logic [15:0] b;
        bit          sub;
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } vector_t;

    result_t q8[$];
    result_t q16[$];
    result_t e8, e16;
    int      check_count = 0;
    int      pass_count  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .STEP(1)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .c_out (c8),
        .ovf   (ovf8)
    );

    serial_adder #(.WIDTH(16), .STEP(4)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .sub   (sub16),
        .a     (a16),
        .b     (b16),
        .busy  (busy16),
        .done  (done16),
        .s     (s16),
        .c_out (c16),
        .ovf   (ovf16)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference arithmetic: plain integer add, overflow judged from operand/result signs.
    function automatic result_t model(input bit wide, input logic [15:0] a, input logic [15:0] b, input bit sub);
        result_t     r;
        logic [15:0] mask;
        logic [15:0] bb;
        logic [16:0] full;
        int          msb;
        mask  = wide ? 16'hFFFF : 16'h00FF;
        msb   = wide ? 15 : 7;
        bb    = sub ? (~b & mask) : (b & mask);
        full  = {1'b0, a & mask} + {1'b0, bb} + {16'h0000, sub};
        r.s   = full[15:0] & mask;
        r.c   = wide ? full[16] : full[8];
        if (sub) r.ovf = (a[msb] != b[msb]) && (r.s[msb] != a[msb]);
        else     r.ovf = (a[msb] == b[msb]) && (r.s[msb] != a[msb]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b,
                                 input bit sub, input result_t exp);
        if (wide) begin
            start16 = 1'b1; a16 = a; b16 = b; sub16 = sub;
            q16.push_back(exp);
        end else begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sub8 = sub;
            q8.push_back(exp);
        end
    endtask

    task automatic waitDone(input bit wide, input int first_cyc, output int dc, output int bc);
        logic bz, dn;
        dc = 0;
        bc = 0;
        for (int k = first_cyc; k < first_cyc + 40; k++) begin
            bz = wide ? busy16 : busy8;
            dn = wide ? done16 : done8;
            checkOutput("busy_done_exclusive", 32'(bz & dn), 32'd0);
            if (dn) begin
                dc = k;
                break;
            end
            if (bz) bc++;
            tick();
        end
    endtask

    task automatic runOp(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input bit sub, input result_t exp, input string tag);
        int          dc, bc;
        logic [15:0] s_now;
        applyStimulus(wide, a, b, sub, exp);
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
        waitDone(wide, 1, dc, bc);
        checkOutput({tag, "_done_cycle"}, dc, wide ? 32'd5 : 32'd9);
        checkOutput({tag, "_busy_cycles"}, bc, wide ? 32'd4 : 32'd8);
        tick();
        checkOutput({tag, "_done_pulse"}, 32'(wide ? done16 : done8), 32'd0);
        s_now = wide ? s16 : {8'h00, s8};
        checkOutput({tag, "_s_held"}, 32'(s_now), 32'(exp.s));
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            checkOutput("q8_expect_pending", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                checkOutput("s8_result", 32'(s8), 32'(e8.s[7:0]));
                checkOutput("c8_result", 32'(c8), 32'(e8.c));
                checkOutput("ovf8_result", 32'(ovf8), 32'(e8.ovf));
            end
        end
        if (done16 === 1'b1) begin
            checkOutput("q16_expect_pending", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                e16 = q16.pop_front();
                checkOutput("s16_result", 32'(s16), 32'(e16.s));
                checkOutput("c16_result", 32'(c16), 32'(e16.c));
                checkOutput("ovf16_result", 32'(ovf16), 32'(e16.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish by 100000ns, expected earlier completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t     vecs [10];
        result_t     r;
        result_t     prev;
        int          dc, bc;
        bit          w;
        logic [15:0] ra, rb;
        bit          rs;

        rst = 1'b1;
        start8 = 1'b0;  sub8 = 1'b0;  a8 = '0;  b8 = '0;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;

        vecs[0] = '{1'b0, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0005, 16'h0007, 1'b1, 16'h00FE, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFE, 1'b1, 1'b0};

        tick();
        tick();
        checkOutput("reset_ctl8", 32'({busy8, done8, c8, ovf8}), 32'd0);
        checkOutput("reset_s8", 32'(s8), 32'd0);
        checkOutput("reset_ctl16", 32'({busy16, done16, c16, ovf16}), 32'd0);
        checkOutput("reset_s16", 32'(s16), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            r = '{vecs[i].s, vecs[i].c, vecs[i].ovf};
            runOp(vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].sub, r, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            w  = i[0];
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (!w) begin
                ra[15:8] = 8'h00;
                rb[15:8] = 8'h00;
            end
            r = model(w, ra, rb, rs);
            runOp(w, ra, rb, rs, r, $sformatf("rand%0d", i));
        end

        // Back-to-back: start held from cycle 2, so it is taken in the DONE cycle.
        r = model(1'b0, 16'h0012, 16'h0034, 1'b0);
        applyStimulus(1'b0, 16'h0012, 16'h0034, 1'b0, r);
        tick();
        start8 = 1'b0;
        tick();
        prev = model(1'b0, 16'h00F0, 16'h000F, 1'b1);
        applyStimulus(1'b0, 16'h00F0, 16'h000F, 1'b1, prev);
        repeat (7) tick();
        checkOutput("b2b_first_done", 32'(done8), 32'd1);
        tick();
        start8 = 1'b0;
        checkOutput("b2b_busy_next", 32'({busy8, done8}), 32'd2);
        waitDone(1'b0, 10, dc, bc);
        checkOutput("b2b_second_done_cycle", dc, 32'd18);
        tick();

        // A start pulse during RUN must be ignored, and s must keep the previous result.
        r = model(1'b0, 16'h005A, 16'h003C, 1'b0);
        applyStimulus(1'b0, 16'h005A, 16'h003C, 1'b0, r);
        tick();
        start8 = 1'b0;
        tick();
        checkOutput("run_holds_prev_s", 32'(s8), 32'(prev.s[7:0]));
        tick();
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1;
        tick();
        start8 = 1'b0;
        waitDone(1'b0, 4, dc, bc);
        checkOutput("run_start_done_cycle", dc, 32'd9);
        tick();
        tick();
        checkOutput("run_start_ignored", 32'({busy8, done8}), 32'd0);

        // Reset in cycle 4 of a run, then a start colliding with reset.
        r = model(1'b0, 16'h00FF, 16'h0001, 1'b0);
        applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0, r);
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst_ctl", 32'({busy8, done8, c8, ovf8}), 32'd0);
        checkOutput("midrst_s", 32'(s8), 32'd0);
        void'(q8.pop_back());
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0;
        tick();
        checkOutput("rst_beats_start", 32'({busy8, done8}), 32'd0);
        rst = 1'b0;
        start8 = 1'b0;
        tick();
        r = model(1'b0, 16'h0001, 16'h0002, 1'b0);
        runOp(1'b0, 16'h0001, 16'h0002, 1'b0, r, "post_rst");

        tick();
        tick();
        checkOutput("q8_drained", 32'(q8.size()), 32'd0);
        checkOutput("q16_drained", 32'(q16.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
